hazard_stall_controller: RTL and testbench

//  Pipeline sequencing controller for the 5-stage RISC-V core; companion to operand forwarding.

---
 rtl/hazard_stall_controller.sv | 119 +++++++++++
 tb/tb_hazard_stall_controller.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, and
// variable-latency memory freeze with timeout, plus saturating stall/flush counters.
module hazard_stall_controller #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IF_ID_Rs1,
  input  logic [4:0]       IF_ID_Rs2,
  input  logic             IF_ID_useRs1,
  input  logic             IF_ID_useRs2,
  input  logic [4:0]       ID_EX_Rd,
  input  logic             ID_EX_memRead,
  input  logic             EX_branchTaken,
  input  logic             EX_MEM_memRead,
  input  logic             EX_MEM_memWrite,
  input  logic             mem_ready,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_bubble,
  output logic             pipe_freeze,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] TIMEOUT_VAL = WCW'(MEM_TIMEOUT);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t         state;
  logic [WCW-1:0] wait_cnt;

  logic mem_acc;
  logic freeze;
  logic load_use;
  logic stall_evt;
  logic flush_evt;

  always_comb begin
    mem_acc  = EX_MEM_memRead | EX_MEM_memWrite;
    freeze   = 1'b0;
    if (state == RUN) freeze = mem_acc & ~mem_ready;
    else              freeze = ~mem_ready & (wait_cnt < TIMEOUT_VAL);
    load_use = ID_EX_memRead & (ID_EX_Rd != 5'd0) &
               ((IF_ID_useRs1 & (ID_EX_Rd == IF_ID_Rs1)) |
                (IF_ID_useRs2 & (ID_EX_Rd == IF_ID_Rs2)));
    stall_evt = freeze | (~EX_branchTaken & load_use);
    flush_evt = ~freeze & EX_branchTaken;
  end

  // Reset drives a flush/bubble so the pipe registers clear alongside this block.
  always_comb begin
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    if (reset) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      IF_ID_flush  = 1'b1;
      ID_EX_bubble = 1'b1;
    end else if (freeze) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      pipe_freeze  = 1'b1;
    end else if (EX_branchTaken) begin
      IF_ID_flush  = 1'b1;
      ID_EX_bubble = 1'b1;
    end else if (load_use) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= RUN;
      wait_cnt        <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (freeze) begin
            state    <= MEM_WAIT;
            wait_cnt <= WCW'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state <= RUN;
          end else if (wait_cnt < TIMEOUT_VAL) begin
            wait_cnt <= wait_cnt + WCW'(1);
          end else begin
            state           <= RUN;
            mem_timeout_err <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: vector table, directed
// multi-cycle sequences, and randomized traffic against a reference model.
module tb_hazard_stall_controller;

  localparam int unsigned TO  = 4;
  localparam int unsigned CW  = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic [4:0]    IF_ID_Rs1, IF_ID_Rs2, ID_EX_Rd;
  logic          IF_ID_useRs1, IF_ID_useRs2, ID_EX_memRead, EX_branchTaken;
  logic          EX_MEM_memRead, EX_MEM_memWrite, mem_ready;
  logic          PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_freeze;
  logic          mem_timeout_err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  hazard_stall_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .IF_ID_Rs1(IF_ID_Rs1), .IF_ID_Rs2(IF_ID_Rs2),
    .IF_ID_useRs1(IF_ID_useRs1), .IF_ID_useRs2(IF_ID_useRs2),
    .ID_EX_Rd(ID_EX_Rd), .ID_EX_memRead(ID_EX_memRead),
    .EX_branchTaken(EX_branchTaken),
    .EX_MEM_memRead(EX_MEM_memRead), .EX_MEM_memWrite(EX_MEM_memWrite),
    .mem_ready(mem_ready),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .ID_EX_bubble(ID_EX_bubble), .pipe_freeze(pipe_freeze),
    .mem_timeout_err(mem_timeout_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_freeze}
  function automatic logic [4:0] ctl();
    return {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_freeze};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    IF_ID_Rs1 = 5'd0; IF_ID_Rs2 = 5'd0; IF_ID_useRs1 = 1'b0; IF_ID_useRs2 = 1'b0;
    ID_EX_Rd = 5'd0; ID_EX_memRead = 1'b0; EX_branchTaken = 1'b0;
    EX_MEM_memRead = 1'b0; EX_MEM_memWrite = 1'b0; mem_ready = 1'b1;
  endtask

  // Advance one clock; inputs are driven and sampled around the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       mr, br, emr, emw, rdy;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[12];

  // Reference model: cycles the current memory access has spent stalled
  // (0 = no outstanding wait), plus plain integer counters.
  int   m_waited, m_stall, m_flush;
  logic m_err;
  logic e_fz, e_lu;
  logic [4:0] e_ctl;

  task automatic model_comb();
    logic acc;
    acc  = EX_MEM_memRead | EX_MEM_memWrite;
    e_lu = ID_EX_memRead && ID_EX_Rd != 0 &&
           ((IF_ID_useRs1 && ID_EX_Rd == IF_ID_Rs1) || (IF_ID_useRs2 && ID_EX_Rd == IF_ID_Rs2));
    if (m_waited == 0) e_fz = acc && !mem_ready;
    else               e_fz = !mem_ready && m_waited < TO;
    if (reset)               e_ctl = 5'b00110;
    else if (e_fz)           e_ctl = 5'b00001;
    else if (EX_branchTaken) e_ctl = 5'b11110;
    else if (e_lu)           e_ctl = 5'b00010;
    else                     e_ctl = 5'b11000;
  endtask

  task automatic model_step();
    if (reset) begin
      m_waited = 0; m_stall = 0; m_flush = 0; m_err = 1'b0;
    end else begin
      if (e_fz || (!EX_branchTaken && e_lu)) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      if (!e_fz && EX_branchTaken)           m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
      if (m_waited == 0) begin
        if (e_fz) m_waited = 1;
      end else if (mem_ready) begin
        m_waited = 0;
      end else if (m_waited < TO) begin
        m_waited++;
      end else begin
        m_waited = 0;
        m_err    = 1'b1;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    #1;
    check("reset_ctl", 32'(ctl()), 32'b00110);
    tick();
    #1;
    check("reset_stall_cnt", 32'(stall_cnt), 0);
    check("reset_flush_cnt", 32'(flush_cnt), 0);
    check("reset_err", 32'(mem_timeout_err), 0);
    reset = 1'b0;
    tick();

    // ---- table: single-cycle control decode from RUN ----
    //            rs1  rs2  u1 u2 rd   mr br emr emw rdy  exp
    vecs[0]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 1, 5'b11000};
    vecs[1]  = '{5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 0, 1, 5'b00010};
    vecs[2]  = '{5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0, 1, 5'b11000};
    vecs[3]  = '{5'd1, 5'd5, 1, 0, 5'd5, 1, 0, 0, 0, 1, 5'b11000};
    vecs[4]  = '{5'd1, 5'd5, 1, 1, 5'd5, 1, 0, 0, 0, 1, 5'b00010};
    vecs[5]  = '{5'd7, 5'd7, 1, 1, 5'd7, 0, 0, 0, 0, 1, 5'b11000};
    vecs[6]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 1, 5'b11110};
    vecs[7]  = '{5'd9, 5'd0, 1, 0, 5'd9, 1, 1, 0, 0, 1, 5'b11110};
    vecs[8]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 5'b00001};
    vecs[9]  = '{5'd9, 5'd0, 1, 0, 5'd9, 1, 1, 1, 0, 0, 5'b00001};
    vecs[10] = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 1, 5'b11000};
    vecs[11] = '{5'd3, 5'd4, 0, 1, 5'd3, 1, 0, 0, 0, 1, 5'b11000};
    for (int i = 0; i < 12; i++) begin
      IF_ID_Rs1 = vecs[i].rs1; IF_ID_Rs2 = vecs[i].rs2;
      IF_ID_useRs1 = vecs[i].u1; IF_ID_useRs2 = vecs[i].u2;
      ID_EX_Rd = vecs[i].rd; ID_EX_memRead = vecs[i].mr; EX_branchTaken = vecs[i].br;
      EX_MEM_memRead = vecs[i].emr; EX_MEM_memWrite = vecs[i].emw; mem_ready = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d_ctl", i), 32'(ctl()), 32'(vecs[i].exp));
      do_reset();
    end
    idle_inputs();

    // ---- load-use: one-cycle stall ----
    ID_EX_memRead = 1'b1; ID_EX_Rd = 5'd5; IF_ID_Rs1 = 5'd5; IF_ID_useRs1 = 1'b1;
    #1 check("lu_stall_ctl", 32'(ctl()), 32'b00010);
    tick();
    ID_EX_memRead = 1'b0;
    #1 check("lu_after_ctl", 32'(ctl()), 32'b11000);
    check("lu_stall_cnt", 32'(stall_cnt), 1);
    idle_inputs();
    do_reset();

    // ---- load to x0 / rs2 unused: no stall ----
    ID_EX_memRead = 1'b1; ID_EX_Rd = 5'd0; IF_ID_Rs1 = 5'd0; IF_ID_useRs1 = 1'b1;
    #1 check("lu_x0_ctl", 32'(ctl()), 32'b11000);
    tick();
    ID_EX_Rd = 5'd5; IF_ID_Rs1 = 5'd1; IF_ID_Rs2 = 5'd5; IF_ID_useRs2 = 1'b0;
    #1 check("lu_rs2_unused_ctl", 32'(ctl()), 32'b11000);
    tick();
    #1 check("no_stall_cnt", 32'(stall_cnt), 0);
    idle_inputs();
    do_reset();

    // ---- memory wait 3 cycles then ready ----
    EX_MEM_memRead = 1'b1; mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 check($sformatf("mw_freeze%0d", c), 32'(pipe_freeze), 1);
      tick();
    end
    mem_ready = 1'b1;
    #1 check("mw_release_ctl", 32'(ctl()), 32'b11000);
    tick();
    EX_MEM_memRead = 1'b0; mem_ready = 1'b0;
    #1 check("mw_back_in_run", 32'(pipe_freeze), 0);
    check("mw_stall_cnt", 32'(stall_cnt), 3);
    check("mw_no_err", 32'(mem_timeout_err), 0);
    idle_inputs();
    do_reset();

    // ---- memory timeout ----
    EX_MEM_memRead = 1'b1; mem_ready = 1'b0;
    for (int c = 0; c < int'(TO); c++) begin
      #1 check($sformatf("to_freeze%0d", c), 32'(pipe_freeze), 1);
      tick();
    end
    #1 check("to_release", 32'(pipe_freeze), 0);
    check("to_release_pc", 32'(PC_write), 1);
    tick();
    EX_MEM_memRead = 1'b0;
    #1 check("to_err_set", 32'(mem_timeout_err), 1);
    check("to_stall_cnt", 32'(stall_cnt), TO);
    tick(); tick();
    #1 check("to_err_sticky", 32'(mem_timeout_err), 1);

    // ---- reset mid-wait ----
    EX_MEM_memWrite = 1'b1; mem_ready = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1 check("rst_wait_ctl", 32'(ctl()), 32'b00110);
    tick();
    reset = 1'b0; EX_MEM_memWrite = 1'b0;
    #1 check("rst_wait_run", 32'(pipe_freeze), 0);
    check("rst_wait_err", 32'(mem_timeout_err), 0);
    check("rst_wait_stall", 32'(stall_cnt), 0);
    check("rst_wait_flush", 32'(flush_cnt), 0);
    idle_inputs();
    do_reset();

    // ---- branch alone over load-use, then under freeze ----
    EX_branchTaken = 1'b1; ID_EX_memRead = 1'b1; ID_EX_Rd = 5'd6; IF_ID_Rs1 = 5'd6; IF_ID_useRs1 = 1'b1;
    #1 check("br_lu_ctl", 32'(ctl()), 32'b11110);
    tick();
    EX_branchTaken = 1'b0; ID_EX_memRead = 1'b0;
    #1 check("br_flush_cnt", 32'(flush_cnt), 1);
    check("br_stall_cnt", 32'(stall_cnt), 0);
    EX_branchTaken = 1'b1; EX_MEM_memRead = 1'b1; mem_ready = 1'b0;
    #1 check("br_frz_ctl0", 32'(ctl()), 32'b00001);
    tick();
    #1 check("br_frz_ctl1", 32'(ctl()), 32'b00001);
    tick();
    mem_ready = 1'b1;
    #1 check("br_after_frz_ctl", 32'(ctl()), 32'b11110);
    tick();
    EX_branchTaken = 1'b0; EX_MEM_memRead = 1'b0;
    #1 check("br_frz_flush_cnt", 32'(flush_cnt), 2);
    check("br_frz_stall_cnt", 32'(stall_cnt), 2);
    idle_inputs();
    do_reset();

    // ---- counter saturation ----
    ID_EX_memRead = 1'b1; ID_EX_Rd = 5'd2; IF_ID_Rs2 = 5'd2; IF_ID_useRs2 = 1'b1;
    for (int c = 0; c < int'(CMAX) + 5; c++) tick();
    #1 check("stall_sat", 32'(stall_cnt), CMAX);
    idle_inputs();
    EX_branchTaken = 1'b1;
    for (int c = 0; c < int'(CMAX) + 5; c++) tick();
    #1 check("flush_sat", 32'(flush_cnt), CMAX);
    idle_inputs();

    // ---- randomized traffic against the reference model ----
    reset = 1'b1;
    model_comb();
    model_step();
    tick();
    for (int c = 0; c < 4000; c++) begin
      reset           = ($urandom_range(0, 79) == 0);
      IF_ID_Rs1       = 5'($urandom_range(0, 3));
      IF_ID_Rs2       = 5'($urandom_range(0, 3));
      IF_ID_useRs1    = 1'($urandom_range(0, 1));
      IF_ID_useRs2    = 1'($urandom_range(0, 1));
      ID_EX_Rd        = 5'($urandom_range(0, 3));
      ID_EX_memRead   = 1'($urandom_range(0, 1));
      EX_branchTaken  = ($urandom_range(0, 5) == 0);
      EX_MEM_memRead  = ($urandom_range(0, 3) == 0);
      EX_MEM_memWrite = ($urandom_range(0, 5) == 0);
      mem_ready       = ($urandom_range(0, 2) == 0);
      #1;
      model_comb();
      check("rnd_ctl", 32'(ctl()), 32'(e_ctl));
      check("rnd_stall_cnt", 32'(stall_cnt), m_stall);
      check("rnd_flush_cnt", 32'(flush_cnt), m_flush);
      check("rnd_err", 32'(mem_timeout_err), 32'(m_err));
      model_step();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
